fp32_div_seq: RTL and testbench
===============================

// Module: fp32_div_seq
// PURPOSE
//  Sequential IEEE-754 single-precision divider, result = a / b; inverse operation of the softmax FP32 multiplier.
//  Normalises exp() terms by their sum in the softmax datapath. Restoring mantissa division, one operation in flight.
//  valid/ready handshake on input and output.
//  Same numeric conventions as the FP32 multiplier: flush-to-zero, truncation (no rounding), saturate to +/-inf.
// PARAMETERS
//  STEPS_PER_CYCLE  1  quotient bits resolved per clock; legal values 1, 5, 25 (must divide 25)
// PORTS
//  clk        in   1   single clock, all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   a/b valid
//  in_ready   out  1   divider idle, operands accepted when in_valid & in_ready
//  a          in   32  dividend, FP32
//  b          in   32  divisor, FP32
//  out_valid  out  1   result valid; held until accepted
//  out_ready  in   1   consumer accepts result when out_valid & out_ready
//  result     out  32  quotient, FP32
//  busy       out  1   high in CALC or NORM
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=32'h0, busy=0, in_ready=1 from the first post-reset cycle.
//  Reset mid-operation aborts. No out_valid is produced for the aborted operands.
//  States: IDLE -> CALC -> NORM -> DONE -> IDLE.
//  Special-case path: IDLE -> DONE directly.
//  in_ready = (state==IDLE), combinational from state only. Operands are registered on the accepting edge.
//  IDLE: on accept, operands are latched and sign = a[31]^b[31].
//    Special cases, checked in priority order:
//    - a[30:23]==0 -> result=32'h00000000, go DONE.
//    - else b[30:23]==0 -> result={sign,8'hFF,23'h0}, go DONE.
//    - else ma={1,a[22:0]}, mb={1,b[22:0]}, rem=ma, q=0, cnt=0, go CALC.
//    Exponent 255 on an input is not special; it is treated as an ordinary biased exponent.
//  CALC: each step: q={q[23:0], rem>=mb}; rem=((rem>=mb)?rem-mb:rem)<<1.
//    rem is 25 bits wide. STEPS_PER_CYCLE steps are chained per clock.
//    Leave for NORM after 25 steps total.
//  NORM (1 cycle): e is a signed 10-bit value.
//    - q[24]=1: mant=q[23:1], e=ea-eb+127.
//    - q[24]=0: mant=q[22:0], e=ea-eb+126.
//    Range check:
//    - e>=255 -> result={sign,8'hFF,23'h0}.
//    - e<=0 -> result=32'h0 (flush).
//    - else result={sign,e[7:0],mant}.
//    Go DONE.
//  DONE: out_valid=1 and result held stable while out_ready=0.
//    On out_valid&out_ready: out_valid=0, go IDLE. The next accept is possible the cycle after.
//  Latency, counting the accepting edge as edge 1: out_valid rises after edge 25/STEPS_PER_CYCLE+2.
//    This is edge 27 for the default. Special-case path: after edge 1.
//  Throughput: one op per (latency + 1 + stall) cycles. No overlap of accept and output.
//  in_valid while busy is ignored. a/b may change freely after acceptance.
// TESTING
//  6.0/2.0: a=40C00000 b=40000000 -> 40400000; out_valid on edge 27; busy high for 26 cycles.
//  1.0/3.0: a=3F800000 b=40400000 -> 3EAAAAAA (truncated, not 3EAAAAAB).
//  Sign: a=C0F00000 (-7.5) b=40200000 (2.5) -> C0400000; a=40000000 b=BF800000 -> C0000000.
//  Zeros: a=00000000 b=40000000 -> 00000000 after 1 edge.
//    a=3F800000 b=0 -> 7F800000; a=BF800000 b=0 -> FF800000; a=0 b=0 -> 00000000.
//  Range: a=7F000000 b=00800000 -> 7F800000 (overflow). a=00800000 b=7F000000 -> 00000000 (underflow flush).
//  Control: out_ready held 0 for 5 cycles -> result/out_valid stable, in_ready=0.
//    rst pulsed at CALC cycle 10 -> out_valid never rises, in_ready=1 next cycle.
//    STEPS_PER_CYCLE=5 -> 6.0/2.0 ready after edge 7.

Source files
------------

// File: rtl/fp32_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp32_div_seq
// Description : Sequential IEEE-754 single-precision divider, result = a / b.
//               Restoring mantissa division with STEPS_PER_CYCLE quotient
//               bits resolved per clock and one operation in flight.
//               Numeric behaviour: denormal inputs are flushed to zero, the
//               quotient is truncated (no rounding), and overflow saturates
//               to +/-inf. Exponent 255 is treated as an ordinary exponent.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               in_valid   - operands a/b valid
//               in_ready   - divider idle; accept on in_valid & in_ready
//               a, b       - dividend / divisor, FP32
//               out_valid  - result valid, held until accepted
//               out_ready  - consumer accepts on out_valid & out_ready
//               result     - quotient, FP32
//               busy       - high while dividing or normalising
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_div_seq #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_NORM = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [5:0] c_STEPS     = 6'(STEPS_PER_CYCLE);
    localparam logic [5:0] c_QBITS     = 6'd25;
    localparam logic [9:0] c_BIAS_HI   = 10'd127;
    localparam logic [9:0] c_BIAS_LO   = 10'd126;

    logic [1:0]  state_q,     state_d;
    logic        sign_q,      sign_d;
    logic [7:0]  ea_q,        ea_d;
    logic [7:0]  eb_q,        eb_d;
    logic [23:0] mb_q,        mb_d;
    logic [24:0] rem_q,       rem_d;
    logic [24:0] quo_q,       quo_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic [31:0] result_q,    result_d;
    logic        out_valid_q, out_valid_d;

    // Chained restoring-division steps for one clock.
    logic [24:0] step_rem;
    logic [24:0] step_quo;
    logic [24:0] step_sel;
    logic        step_ge;

    always_comb begin
        step_rem = rem_q;
        step_quo = quo_q;
        step_sel = rem_q;
        step_ge  = 1'b0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            step_ge  = (step_rem >= {1'b0, mb_q});
            step_quo = {step_quo[23:0], step_ge};
            step_sel = step_ge ? (step_rem - {1'b0, mb_q}) : step_rem;
            // Remainder stays below 2*mb, so the shift never loses a set bit.
            step_rem = step_sel << 1;
        end
    end

    // Normalisation: quotient of two [1,2) mantissas lies in (0.5,2).
    logic [9:0]  norm_e;
    logic [22:0] norm_mant;
    logic [5:0]  cnt_next;

    always_comb begin
        norm_e    = {2'b00, ea_q} - {2'b00, eb_q} + (quo_q[24] ? c_BIAS_HI : c_BIAS_LO);
        norm_mant = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
        cnt_next  = {1'b0, cnt_q} + c_STEPS;
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        mb_d        = mb_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            c_ST_IDLE: begin
                if (in_valid) begin
                    sign_d = a[31] ^ b[31];
                    ea_d   = a[30:23];
                    eb_d   = b[30:23];
                    if (a[30:23] == 8'h00) begin
                        // Zero/denormal dividend: unsigned zero wins over x/0.
                        result_d    = 32'h0000_0000;
                        out_valid_d = 1'b1;
                        state_d     = c_ST_DONE;
                    end else if (b[30:23] == 8'h00) begin
                        result_d    = {a[31] ^ b[31], 8'hFF, 23'h0};
                        out_valid_d = 1'b1;
                        state_d     = c_ST_DONE;
                    end else begin
                        mb_d    = {1'b1, b[22:0]};
                        rem_d   = {2'b01, a[22:0]};
                        quo_d   = 25'h0;
                        cnt_d   = 5'd0;
                        state_d = c_ST_CALC;
                    end
                end
            end
            c_ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_next[4:0];
                if (cnt_next == c_QBITS) begin
                    state_d = c_ST_NORM;
                end
            end
            c_ST_NORM: begin
                if ($signed(norm_e) >= $signed(10'd255)) begin
                    result_d = {sign_q, 8'hFF, 23'h0};
                end else if ($signed(norm_e) <= $signed(10'd0)) begin
                    result_d = 32'h0000_0000;
                end else begin
                    result_d = {sign_q, norm_e[7:0], norm_mant};
                end
                out_valid_d = 1'b1;
                state_d     = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_ST_IDLE;
            sign_q      <= 1'b0;
            ea_q        <= 8'h00;
            eb_q        <= 8'h00;
            mb_q        <= 24'h0;
            rem_q       <= 25'h0;
            quo_q       <= 25'h0;
            cnt_q       <= 5'd0;
            result_q    <= 32'h0000_0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            mb_q        <= mb_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == c_ST_IDLE);
        busy      = (state_q == c_ST_CALC) || (state_q == c_ST_NORM);
        out_valid = out_valid_q;
        result    = result_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_div_seq
// Description : Directed self-checking bench for fp32_div_seq. One instance
//               uses one quotient bit per clock, a second uses five.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    logic        in_valid5 = 1'b0;
    logic        in_ready5;
    logic        out_valid5;
    logic        out_ready5 = 1'b0;
    logic [31:0] result5;
    logic        busy5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp32_div_seq #(.STEPS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    fp32_div_seq #(.STEPS_PER_CYCLE(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid5), .in_ready(in_ready5),
        .a(a), .b(b),
        .out_valid(out_valid5), .out_ready(out_ready5),
        .result(result5), .busy(busy5)
    );

    // Presents one operand pair to the 1-step instance and waits for
    // out_valid. edges counts rising edges with the accepting edge as 1;
    // a timeout leaves edges at 100.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         output int edges, output int busy_cnt);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        edges = 1;
        busy_cnt = 0;
        while (!out_valid && edges < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b res=%h busy=%b expected ov=0 res=00000000 busy=0",
                     out_valid, result, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int e, bc;
        issue(32'h40C00000, 32'h40000000, e, bc);
        checks++;
        if (e !== 27) begin
            errors++;
            $display("FAIL div6_2_latency: got edge %0d expected 27", e);
        end
        checks++;
        if (result !== 32'h40400000) begin
            errors++;
            $display("FAIL div6_2_result: got %h expected 40400000", result);
        end
        checks++;
        if (bc !== 26) begin
            errors++;
            $display("FAIL div6_2_busy_cycles: got %0d expected 26", bc);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_flags: got busy=%b in_ready=%b expected busy=0 in_ready=0", busy, in_ready);
        end
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handoff: got ov=%b in_ready=%b expected ov=0 in_ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [6] = '{32'h3F800000, 32'hC0F00000, 32'h40000000,
                                32'h7F000000, 32'h00800000, 32'h3FC00000};
        logic [31:0] vb [6] = '{32'h40400000, 32'h40200000, 32'hBF800000,
                                32'h00800000, 32'h7F000000, 32'h3FC00000};
        logic [31:0] vr [6] = '{32'h3EAAAAAA, 32'hC0400000, 32'hC0000000,
                                32'h7F800000, 32'h00000000, 32'h3F800000};
        int e, bc;
        for (int i = 0; i < 6; i++) begin
            issue(va[i], vb[i], e, bc);
            checks++;
            if (e !== 27 || result !== vr[i]) begin
                errors++;
                $display("FAIL vector_%0d: got %h at edge %0d expected %h at edge 27",
                         i, result, e, vr[i]);
            end
            release_out();
        end
    endtask

    task automatic test_special();
        logic [31:0] va [4] = '{32'h00000000, 32'h3F800000, 32'hBF800000, 32'h80000000};
        logic [31:0] vb [4] = '{32'h40000000, 32'h00000000, 32'h00000000, 32'h00000000};
        logic [31:0] vr [4] = '{32'h00000000, 32'h7F800000, 32'hFF800000, 32'h00000000};
        int e, bc;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], e, bc);
            checks++;
            if (e !== 1 || result !== vr[i] || bc !== 0) begin
                errors++;
                $display("FAIL special_%0d: got %h at edge %0d busy=%0d expected %h at edge 1 busy=0",
                         i, result, e, bc, vr[i]);
            end
            release_out();
        end
    endtask

    task automatic test_stall();
        int e, bc;
        issue(32'h40C00000, 32'h40000000, e, bc);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 32'h3F800000;
            b = 32'h40400000;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h40400000 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got ov=%b res=%h in_ready=%b expected ov=1 res=40400000 in_ready=0",
                         i, out_valid, result, in_ready);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got ov=%b in_ready=%b busy=%b expected 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        issue(32'h3F800000, 32'h40400000, e, bc);
        // Offer the next pair in the same cycle the result is taken.
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 32'h40C00000;
        b = 32'h40000000;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got in_ready=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got in_ready=%b busy=%b expected 0 1", in_ready, busy);
        end
        e = 1;
        while (!out_valid && e < 100) begin
            @(negedge clk);
            e++;
        end
        checks++;
        if (e !== 27 || result !== 32'h40400000) begin
            errors++;
            $display("FAIL b2b_second: got %h at edge %0d expected 40400000 at edge 27", result, e);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got in_ready=%b busy=%b ov=%b expected 1 0 0",
                     in_ready, busy, out_valid);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_output: got %0d valid cycles expected 0", seen);
        end
    endtask

    task automatic test_steps5();
        int e;
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid5 = 1'b1;
        @(negedge clk);
        in_valid5 = 1'b0;
        e = 1;
        while (!out_valid5 && e < 100) begin
            @(negedge clk);
            e++;
        end
        checks++;
        if (e !== 7 || result5 !== 32'h40400000) begin
            errors++;
            $display("FAIL steps5_div6_2: got %h at edge %0d expected 40400000 at edge 7", result5, e);
        end
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h40400000;
        out_ready5 = 1'b1;
        @(negedge clk);
        out_ready5 = 1'b0;
        in_valid5 = 1'b1;
        @(negedge clk);
        in_valid5 = 1'b0;
        e = 1;
        while (!out_valid5 && e < 100) begin
            @(negedge clk);
            e++;
        end
        checks++;
        if (e !== 7 || result5 !== 32'h3EAAAAAA) begin
            errors++;
            $display("FAIL steps5_div1_3: got %h at edge %0d expected 3EAAAAAA at edge 7", result5, e);
        end
        out_ready5 = 1'b1;
        @(negedge clk);
        out_ready5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_special();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_steps5();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
